alu_register_top: RTL and testbench

//  Registered N-bit ALU: samples operands a/b and opcode uc into input registers, then

---
 rtl/alu_register_top.sv | 117 +++++++++++
 tb/tb_alu_register_top.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_register_top.sv
// Registered N-bit ALU: input registers feed an 8-op ALU with {N,Z,C,V} flags.
// Define ALU_OUTREG_EN to add an output register stage on r and f.
module alu_register_top #(
   parameter int N = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] uc,
   output logic [N-1:0] r,
   output logic [3:0]   f
);

   localparam int SW = $clog2(N);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLL = 3'b101,
      OP_SRL = 3'b110,
      OP_NOT = 3'b111
   } op_t;

   logic [N-1:0] a_d, a_q, b_d, b_q;
   op_t          op_d, op_q;
   logic [N-1:0] r_d;
   logic [3:0]   f_d;

   logic [SW-1:0] sh;
   logic [N:0]    sum, diff, shl, shr;
   logic          carry, ovf;
   logic          unused_uc;

   assign unused_uc = ^uc[N-1:3];

   always_comb begin
      a_d  = a;
      b_d  = b;
      op_d = op_t'(uc[2:0]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= OP_ADD;
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         op_q <= op_d;
      end
   end

   // One extra bit on each side of the shifters captures the last bit shifted out.
   always_comb begin
      r_d   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      sh    = b_q[SW-1:0];
      sum   = {1'b0, a_q} + {1'b0, b_q};
      diff  = {1'b0, a_q} - {1'b0, b_q};
      shl   = {1'b0, a_q} << sh;
      shr   = {a_q, 1'b0} >> sh;
      case (op_q)
         OP_ADD: begin
            r_d   = sum[N-1:0];
            carry = sum[N];
            ovf   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
         end
         OP_SUB: begin
            r_d   = diff[N-1:0];
            carry = ~diff[N];
            ovf   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
         end
         OP_AND: r_d = a_q & b_q;
         OP_OR:  r_d = a_q | b_q;
         OP_XOR: r_d = a_q ^ b_q;
         OP_SLL: begin
            r_d   = shl[N-1:0];
            carry = shl[N];
         end
         OP_SRL: begin
            r_d   = shr[N:1];
            carry = shr[0];
         end
         OP_NOT: r_d = ~a_q;
         default: r_d = '0;
      endcase
      f_d = {r_d[N-1], (r_d == '0), carry, ovf};
   end

`ifdef ALU_OUTREG_EN
   logic [N-1:0] r_q;
   logic [3:0]   f_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
         f_q <= 4'b0100;
      end else begin
         r_q <= r_d;
         f_q <= f_d;
      end
   end

   assign r = r_q;
   assign f = f_q;
`else
   assign r = r_d;
   assign f = f_d;
`endif

endmodule

// File: tb/tb_alu_register_top.sv
// Self-checking bench for alu_register_top: directed vectors, randomized
// pipelined stream against a behavioural model, and mid-stream reset.
module tb_alu_register_top;

   localparam int N  = 256;
   localparam int SW = $clog2(N);
`ifdef ALU_OUTREG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic         clk;
   logic         rst;
   logic [N-1:0] a, b, uc;
   logic [N-1:0] r;
   logic [3:0]   f;

   int total;
   int bad;
   logic [N+3:0] expQ[$];

   alu_register_top #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .uc  (uc),
      .r   (r),
      .f   (f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: result and flags from plain arithmetic on the operands.
   function automatic logic [N+3:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [2:0] op);
      logic [N-1:0] res;
      logic         c, v;
      int           sh;
      sh  = int'(y[SW-1:0]);
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (op)
         3'd0: begin
            res = x + y;
            c   = (res < x);
            v   = (x[N-1] == y[N-1]) && (res[N-1] != x[N-1]);
         end
         3'd1: begin
            res = x - y;
            c   = (x >= y);
            v   = (x[N-1] != y[N-1]) && (res[N-1] != x[N-1]);
         end
         3'd2: res = x & y;
         3'd3: res = x | y;
         3'd4: res = x ^ y;
         3'd5: begin
            res = x << sh;
            c   = (sh == 0) ? 1'b0 : (((x >> (N - sh)) & 1) != 0);
         end
         3'd6: begin
            res = x >> sh;
            c   = (sh == 0) ? 1'b0 : (((x >> (sh - 1)) & 1) != 0);
         end
         default: res = ~x;
      endcase
      return {res, res[N-1], (res == 0), c, v};
   endfunction

   function automatic logic [N-1:0] randWide();
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i += 32) v = (v << 32) | N'($urandom());
      return v;
   endfunction

   function automatic logic [N-1:0] randOperand();
      logic [N-1:0] ones;
      ones = '1;
      case ($urandom_range(0, 4))
         0: return N'($urandom_range(0, 300));
         1: return ones - N'($urandom_range(0, 3));
         2: return ones >> 1;
         3: return N'(1) << (N - 1);
         default: return randWide();
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [N+3:0] observed,
                              input logic [N+3:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got r=%h f=%b, want r=%h f=%b", tag,
                  observed[N+3:4], observed[3:0], expected[N+3:4], expected[3:0]);
      end
   endtask

   // Hold one operand set for L edges, then check against constants.
   task automatic applyStimulus(input string tag, input logic [N-1:0] ta,
                                input logic [N-1:0] tb, input logic [N-1:0] tuc,
                                input logic [N-1:0] expR, input logic [3:0] expF);
      a  = ta;
      b  = tb;
      uc = tuc;
      repeat (L) @(posedge clk);
      #1;
      checkOutput(tag, {r, f}, {expR, expF});
   endtask

   // Drive a new operand set every cycle; each result is due L edges later.
   task automatic streamCycle(input logic [N-1:0] ta, input logic [N-1:0] tb,
                              input logic [N-1:0] tuc);
      a  = ta;
      b  = tb;
      uc = tuc;
      expQ.push_back(model(ta, tb, tuc[2:0]));
      @(posedge clk);
      #1;
      if (expQ.size() >= L) checkOutput("pipe", {r, f}, expQ.pop_front());
   endtask

   logic [N-1:0] ones, maxPos, minNeg, ucHigh;

   initial begin
      total  = 0;
      bad    = 0;
      ones   = '1;
      maxPos = ones >> 1;
      minNeg = ~maxPos;
      ucHigh = ones << 3;

      rst = 1'b0;
      a   = randWide();
      b   = randWide();
      uc  = randWide();
      #3;
      checkOutput("reset_async", {r, f}, {{N{1'b0}}, 4'b0100});
      @(posedge clk);
      #1;
      checkOutput("reset_held", {r, f}, {{N{1'b0}}, 4'b0100});
      #2 rst = 1'b1;

      applyStimulus("and_1_1",  N'(1), N'(1), N'(3'b010), N'(1),  4'b0000);
      applyStimulus("add_1_1",  N'(1), N'(1), N'(3'b000), N'(2),  4'b0000);
      applyStimulus("or_1_1",   N'(1), N'(1), N'(3'b011), N'(1),  4'b0000);
      applyStimulus("sub_1_1",  N'(1), N'(1), N'(3'b001), '0,     4'b0110);
      applyStimulus("sub_0_1",  '0,    N'(1), N'(3'b001), ones,   4'b1000);
      applyStimulus("add_wrap", ones,  N'(1), N'(3'b000), '0,     4'b0110);
      applyStimulus("add_ovf",  maxPos, N'(1), N'(3'b000), minNeg, 4'b1001);
      applyStimulus("sll_1_4",  N'(1), N'(4), N'(3'b101), N'(16), 4'b0000);
      applyStimulus("srl_3_1",  N'(3), N'(1), N'(3'b110), N'(1),  4'b0010);
      applyStimulus("not_0",    '0,    N'(1), N'(3'b111), ones,   4'b1000);
      applyStimulus("uc_upper", N'(1), N'(1), ucHigh,     N'(2),  4'b0000);

      expQ.delete();
      for (int i = 0; i < 200; i++) begin
         streamCycle(randOperand(), randOperand(), randWide());
      end

      // Pulse reset mid-stream: outputs clear at once and stale results are dropped.
      #2 rst = 1'b0;
      #1;
      checkOutput("reset_mid", {r, f}, {{N{1'b0}}, 4'b0100});
      expQ.delete();
      a = randWide();
      b = randWide();
      uc = randWide();
      @(posedge clk);
      #1;
      checkOutput("reset_mid_held", {r, f}, {{N{1'b0}}, 4'b0100});
      #2 rst = 1'b1;

      for (int i = 0; i < 200; i++) begin
         streamCycle(randOperand(), randOperand(), randWide());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
